// File: rtl/scaler_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module  : scaler_fetch_sched
// Purpose : Round-robin shared access to the scaler ROM, with a tagged
//           per-requester output register so that repeated indices skip the ROM.
// Revision: 1.0 - initial release
// ============================================================================
module scaler_fetch_sched #(
    parameter int NUM_REQ       = 4,
    parameter int ADDR_WIDTH    = 4,
    parameter int FEATURE_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [NUM_REQ*FEATURE_WIDTH-1:0] scaler_out,
    input  logic                             clear,
    output logic                             busy,
    output logic                             mem_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [FEATURE_WIDTH-1:0]         mem_dout
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [c_PTR_W-1:0]       r_rr_ptr;
    logic [c_PTR_W-1:0]       r_grant;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [NUM_REQ-1:0]       r_tag_valid;
    logic [ADDR_WIDTH-1:0]    r_tag_addr [NUM_REQ];
    logic [FEATURE_WIDTH-1:0] r_scaler   [NUM_REQ];
    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic                     r_mem_en;
    logic [ADDR_WIDTH-1:0]    r_mem_addr;

    logic                     w_any;
    logic [c_PTR_W-1:0]       w_winner;
    logic [c_PTR_W-1:0]       w_next_ptr;
    logic [ADDR_WIDTH-1:0]    w_addr;
    logic                     w_accept;
    logic                     w_hit;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int v_idx;
            v_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[v_idx]) begin
                w_any    = 1'b1;
                w_winner = c_PTR_W'(v_idx);
            end
        end
    end

    assign w_addr     = req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_accept   = (r_state == ST_IDLE) && w_any;
    assign w_hit      = w_accept && r_tag_valid[w_winner] && !clear &&
                        (r_tag_addr[w_winner] == w_addr);
    assign w_next_ptr = (w_winner == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_addr      <= '0;
            r_tag_valid <= '0;
            r_rsp_valid <= '0;
            r_mem_en    <= 1'b0;
            r_mem_addr  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_tag_addr[i] <= '0;
                r_scaler[i]   <= '0;
            end
        end else begin
            r_rsp_valid <= '0;
            r_mem_en    <= 1'b0;
            if (clear) begin
                r_tag_valid <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant  <= w_winner;
                        r_addr   <= w_addr;
                        r_rr_ptr <= w_next_ptr;
                        if (w_hit) begin
                            r_rsp_valid[w_winner] <= 1'b1;
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= w_addr;
                            r_state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Data always lands; a simultaneous clear keeps the tag invalid.
                    r_scaler[r_grant]    <= mem_dout;
                    r_rsp_valid[r_grant] <= 1'b1;
                    r_tag_addr[r_grant]  <= r_addr;
                    if (!clear) begin
                        r_tag_valid[r_grant] <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_out
            assign scaler_out[gi*FEATURE_WIDTH +: FEATURE_WIDTH] = r_scaler[gi];
        end
    endgenerate

    assign rsp_valid = r_rsp_valid;
    assign mem_en    = r_mem_en;
    assign mem_addr  = r_mem_addr;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
